// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with request-to-send, ACK check and timeout
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data_i,
   input  logic       tx_start_i,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic       ps2c_oe_o,
   output logic       ps2d_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);
   localparam int MAX_IR = INHIBIT_CYCLES > REQ_CYCLES ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_C  = MAX_IR > TIMEOUT_CYCLES ? MAX_IR : TIMEOUT_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, FIN, FAIL} state_t;

   state_t          state_q;
   logic [1:0]      c_sync_q, d_sync_q;
   logic            c_prev_q;
   logic [7:0]      data_q;
   logic [3:0]      idx_q;
   logic [CW-1:0]   cnt_q;
   logic            fall_d, bit_d, timeout_d;

   // Two-flop synchronizers on both pins; idle bus level is high
   always_ff @(posedge clock) begin
      if (!resetn) begin
         c_sync_q <= 2'b11;
         d_sync_q <= 2'b11;
         c_prev_q <= 1'b1;
      end else begin
         c_sync_q <= {c_sync_q[0], ps2c_i};
         d_sync_q <= {d_sync_q[0], ps2d_i};
         c_prev_q <= c_sync_q[1];
      end
   end

   // Device falling edge, bit to present next (data, odd parity, stop) and timeout hit
   always_comb begin
      fall_d    = c_prev_q & ~c_sync_q[1];
      bit_d     = idx_q < 4'd8 ? data_q[idx_q[2:0]] : idx_q == 4'd8 ? ~^data_q : 1'b1;
      timeout_d = cnt_q == CW'(TIMEOUT_CYCLES - 1);
   end

   // Transfer sequencer with registered line drives and status
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= IDLE;
         ps2c_oe_o <= 1'b0;
         ps2d_oe_o <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         error_o   <= 1'b0;
         data_q    <= 8'h00;
         idx_q     <= 4'd0;
         cnt_q     <= '0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            IDLE: if (tx_start_i) begin
               data_q    <= tx_data_i;
               busy_o    <= 1'b1;
               error_o   <= 1'b0;
               ps2c_oe_o <= 1'b1;
               ps2d_oe_o <= 1'b0;
               cnt_q     <= '0;
               state_q   <= INHIBIT;
            end
            INHIBIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                  cnt_q     <= '0;
                  ps2d_oe_o <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(REQ_CYCLES - 1)) begin
                  cnt_q     <= '0;
                  idx_q     <= 4'd0;
                  ps2c_oe_o <= 1'b0;
                  state_q   <= SEND;
               end
            end
            SEND, ACK, WAIT_IDLE: begin
               cnt_q <= cnt_q + CW'(1);
               if (timeout_d || (state_q == ACK && fall_d && d_sync_q[1])) begin
                  ps2c_oe_o <= 1'b0;
                  ps2d_oe_o <= 1'b0;
                  done_o    <= 1'b1;
                  error_o   <= 1'b1;
                  state_q   <= FAIL;
               end else if (state_q == SEND && fall_d) begin
                  ps2d_oe_o <= ~bit_d;
                  idx_q     <= idx_q + 4'd1;
                  if (idx_q == 4'd9) state_q <= ACK;
               end else if (state_q == ACK && fall_d) begin
                  state_q <= WAIT_IDLE;
               end else if (state_q == WAIT_IDLE && c_sync_q[1] && d_sync_q[1]) begin
                  done_o  <= 1'b1;
                  error_o <= 1'b0;
                  state_q <= FIN;
               end
            end
            FIN: begin
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            FAIL: begin
               busy_o  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple clocking PS/2 device model
module tb_ps2_host_tx;
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       dev_c_low = 1'b0, dev_d_low = 1'b0;
   logic       ps2c, ps2d;
   logic       ps2c_oe, ps2d_oe, busy, done, error;
   int         n_vec = 0, n_bad = 0, n_done = 0;
   logic       last_err = 1'b0;
   int         c_hi, d_rise, pre, n;
   logic [10:0] fr;

   assign ps2c = ~(ps2c_oe | dev_c_low);
   assign ps2d = ~(ps2d_oe | dev_d_low);

   ps2_host_tx #(.INHIBIT_CYCLES(20), .REQ_CYCLES(5), .TIMEOUT_CYCLES(1000)) dut (
      .clock(clock), .resetn(resetn), .tx_data_i(tx_data), .tx_start_i(tx_start),
      .ps2c_i(ps2c), .ps2d_i(ps2d), .ps2c_oe_o(ps2c_oe), .ps2d_oe_o(ps2d_oe),
      .busy_o(busy), .done_o(done), .error_o(error));

   always #10 clock = ~clock;

   // Count done pulses and capture error alongside each
   always @(negedge clock) if (done) begin
      n_done   = n_done + 1;
      last_err = error;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
   endtask

   task automatic start(input logic [7:0] b, output int hi, output int rise);
      check("pre_coe", 32'(ps2c_oe), 0);
      tx_data  = b;
      tx_start = 1'b1;
      tick;
      tx_start = 1'b0;
      check("busy_acc", 32'(busy), 1);
      check("err_clr", 32'(error), 0);
      hi   = 0;
      rise = -1;
      while (ps2c_oe && hi < 100) begin
         if (ps2d_oe && rise < 0) rise = hi;
         hi++;
         tick;
      end
   endtask

   task automatic device(input bit ack, input bit inject, input bit rst, output logic [10:0] frame);
      int base;
      base  = n_done;
      frame = '0;
      repeat (10) tick;
      frame[0] = ps2d;
      for (int i = 0; i < 10; i++) begin
         dev_c_low = 1'b1;
         for (int k = 0; k < 30; k++) begin
            if (inject && i == 2 && k == 0) begin
               tx_data  = 8'h00;
               tx_start = 1'b1;
            end else tx_start = 1'b0;
            tick;
         end
         tx_start  = 1'b0;
         dev_c_low = 1'b0;
         frame[i+1] = ps2d;
         if (rst && i == 3) begin
            resetn = 1'b0;
            tick;
            check("rst_coe", 32'(ps2c_oe), 0);
            check("rst_doe", 32'(ps2d_oe), 0);
            check("rst_busy", 32'(busy), 0);
            resetn = 1'b1;
            repeat (3) tick;
            check("rst_nodone", 32'(n_done - base), 0);
            return;
         end
         repeat (30) tick;
      end
      check("pre_ack_done", 32'(n_done - base), 0);
      check("pre_ack_busy", 32'(busy), 1);
      dev_d_low = ack;
      dev_c_low = 1'b1;
      repeat (30) tick;
      dev_c_low = 1'b0;
      repeat (5) tick;
      dev_d_low = 1'b0;
   endtask

   task automatic wait_idle;
      int w;
      w = 0;
      while (busy && w < 3000) begin
         tick;
         w++;
      end
      check("idle", 32'(busy), 0);
   endtask

   initial begin
      repeat (3) tick;
      check("rst_c", 32'(ps2c_oe), 0);
      check("rst_d", 32'(ps2d_oe), 0);
      check("rst_busy0", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(error), 0);
      resetn = 1'b1;
      tick;
      // 0xED, device ACKs; also checks inhibit/request timing
      pre = n_done;
      start(8'hED, c_hi, d_rise);
      check("coe_hi", 32'(c_hi), 25);
      check("doe_rise", 32'(d_rise), 20);
      device(1'b1, 1'b0, 1'b0, fr);
      check("frame_ed", 32'(fr), 32'h7DA);
      wait_idle;
      check("done_ed", 32'(n_done - pre), 1);
      check("err_ed", 32'(last_err), 0);
      // 0xFF, device NACKs
      pre = n_done;
      start(8'hFF, c_hi, d_rise);
      device(1'b0, 1'b0, 1'b0, fr);
      check("frame_ff", 32'(fr), 32'h7FE);
      wait_idle;
      check("done_nack", 32'(n_done - pre), 1);
      check("err_nack", 32'(last_err), 1);
      check("nack_c", 32'(ps2c_oe), 0);
      check("nack_d", 32'(ps2d_oe), 0);
      check("err_held", 32'(error), 1);
      // 0xF4 accepted after a failure
      pre = n_done;
      start(8'hF4, c_hi, d_rise);
      check("coe_hi_f4", 32'(c_hi), 25);
      device(1'b1, 1'b0, 1'b0, fr);
      check("frame_f4", 32'(fr), 32'h5E8);
      wait_idle;
      check("done_f4", 32'(n_done - pre), 1);
      check("err_f4", 32'(last_err), 0);
      // 0x01 with a stray tx_start of 0x00 during SEND
      pre = n_done;
      start(8'h01, c_hi, d_rise);
      device(1'b1, 1'b1, 1'b0, fr);
      check("frame_01", 32'(fr), 32'h402);
      wait_idle;
      check("done_01", 32'(n_done - pre), 1);
      check("err_01", 32'(last_err), 0);
      // Silent device: timeout
      start(8'hA5, c_hi, d_rise);
      n = 0;
      while (!done && n < 2000) begin
         tick;
         n++;
      end
      check("tmo_cyc", 32'(n), 1000);
      check("tmo_err", 32'(error), 1);
      check("tmo_c", 32'(ps2c_oe), 0);
      check("tmo_d", 32'(ps2d_oe), 0);
      wait_idle;
      // Reset after the 4th data bit, then a fresh 0xFF
      start(8'hFF, c_hi, d_rise);
      device(1'b1, 1'b0, 1'b1, fr);
      repeat (5) tick;
      pre = n_done;
      start(8'hFF, c_hi, d_rise);
      device(1'b1, 1'b0, 1'b0, fr);
      check("frame_ff2", 32'(fr), 32'h7FE);
      wait_idle;
      check("done_ff2", 32'(n_done - pre), 1);
      check("err_ff2", 32'(last_err), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
